// File: rtl/dual_port_memory_if.sv
// Request/response bundle for dual_port_memory.
// Fetch port (I*) and load/store port (D*); the core is master.
interface dual_port_memory_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                    i_IReadEnable;
  logic [ADDR_WIDTH-1:0]   i_IAddress;
  logic [DATA_WIDTH-1:0]   o_IData;
  logic                    o_IValid;
  logic                    o_IFault;
  logic                    i_DReadEnable;
  logic                    i_DWriteEnable;
  logic [DATA_WIDTH/8-1:0] i_DByteEnable;
  logic [ADDR_WIDTH-1:0]   i_DAddress;
  logic [DATA_WIDTH-1:0]   i_DDataIn;
  logic [DATA_WIDTH-1:0]   o_DDataOut;
  logic                    o_DValid;
  logic                    o_DFault;

  modport master (
    output i_IReadEnable, i_IAddress,
    output i_DReadEnable, i_DWriteEnable,
    output i_DByteEnable, i_DAddress, i_DDataIn,
    input  o_IData, o_IValid, o_IFault,
    input  o_DDataOut, o_DValid, o_DFault
  );

  modport slave (
    input  i_IReadEnable, i_IAddress,
    input  i_DReadEnable, i_DWriteEnable,
    input  i_DByteEnable, i_DAddress, i_DDataIn,
    output o_IData, o_IValid, o_IFault,
    output o_DDataOut, o_DValid, o_DFault
  );
endinterface

// File: rtl/dual_port_memory.sv
// Shared word array with a fetch read port and a byte-lane data port.
// Ports: i_Clock, i_Reset (async, active high), bus (slave modport).
module dual_port_memory #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int DEPTH_WORDS  = 16384,
  parameter int READ_LATENCY = 1,
  parameter int WRITE_MODE   = 0
) (
  input logic             i_Clock,
  input logic             i_Reset,
  dual_port_memory_if.slave bus
);
  localparam int NB  = DATA_WIDTH / 8;
  localparam int OFF = $clog2(NB);
  localparam int IDX = $clog2(DEPTH_WORDS);
  localparam int HI  = OFF + IDX;
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK =
    ADDR_WIDTH'((1 << OFF) - 1);

  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_lat
    $error("READ_LATENCY must be 1 or 2");
  end
  if (DATA_WIDTH % 8 != 0) begin : g_bad_dw
    $error("DATA_WIDTH must be a multiple of 8");
  end
  if ((DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
    $error("DEPTH_WORDS must be a power of 2");
  end

  typedef logic [DATA_WIDTH-1:0] word_t;

  word_t mem [DEPTH_WORDS];

  // Misaligned offset or any bit above the word index set.
  function automatic logic bad_addr(
    input logic [ADDR_WIDTH-1:0] a
  );
    return (|(a & OFF_MASK)) | (|(a >> HI));
  endfunction

  logic [IDX-1:0] iidx;
  logic [IDX-1:0] didx;
  logic           ireq;
  logic           dreq;
  logic           ifault;
  logic           dfault;
  word_t          iret;
  word_t          dold;
  word_t          dmerge;
  word_t          dret;

  assign iidx   = IDX'(bus.i_IAddress >> OFF);
  assign didx   = IDX'(bus.i_DAddress >> OFF);
  assign ireq   = bus.i_IReadEnable;
  assign dreq   = bus.i_DReadEnable | bus.i_DWriteEnable;
  assign ifault = bad_addr(bus.i_IAddress);
  assign dfault = bad_addr(bus.i_DAddress);

  // Both ports sample the array before this edge's write lands,
  // so a colliding fetch always sees the pre-write word.
  always_comb begin
    iret   = ifault ? '0 : mem[iidx];
    dold   = mem[didx];
    dmerge = dold;
    for (int k = 0; k < NB; k++) begin
      if (bus.i_DByteEnable[k]) begin
        dmerge[8*k +: 8] = bus.i_DDataIn[8*k +: 8];
      end
    end
    dret = dold;
    if (bus.i_DWriteEnable && WRITE_MODE == 0) begin
      dret = dmerge;
    end
    if (dfault) begin
      dret = '0;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (!i_Reset && bus.i_DWriteEnable && !dfault) begin
      mem[didx] <= dmerge;
    end
  end

  logic  s1_iv;
  logic  s1_if;
  logic  s1_dv;
  logic  s1_df;
  word_t s1_id;
  word_t s1_dd;

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      s1_iv <= 1'b0;
      s1_if <= 1'b0;
      s1_dv <= 1'b0;
      s1_df <= 1'b0;
      s1_id <= '0;
      s1_dd <= '0;
    end else begin
      s1_iv <= ireq;
      s1_if <= ireq & ifault;
      s1_dv <= dreq;
      s1_df <= dreq & dfault;
      if (ireq) s1_id <= iret;
      if (dreq) s1_dd <= dret;
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic  s2_iv;
    logic  s2_if;
    logic  s2_dv;
    logic  s2_df;
    word_t s2_id;
    word_t s2_dd;

    always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) begin
        s2_iv <= 1'b0;
        s2_if <= 1'b0;
        s2_dv <= 1'b0;
        s2_df <= 1'b0;
        s2_id <= '0;
        s2_dd <= '0;
      end else begin
        s2_iv <= s1_iv;
        s2_if <= s1_if;
        s2_dv <= s1_dv;
        s2_df <= s1_df;
        if (s1_iv) s2_id <= s1_id;
        if (s1_dv) s2_dd <= s1_dd;
      end
    end

    assign bus.o_IValid   = s2_iv;
    assign bus.o_IFault   = s2_if;
    assign bus.o_IData    = s2_id;
    assign bus.o_DValid   = s2_dv;
    assign bus.o_DFault   = s2_df;
    assign bus.o_DDataOut = s2_dd;
  end else begin : g_lat1
    assign bus.o_IValid   = s1_iv;
    assign bus.o_IFault   = s1_if;
    assign bus.o_IData    = s1_id;
    assign bus.o_DValid   = s1_dv;
    assign bus.o_DFault   = s1_df;
    assign bus.o_DDataOut = s1_dd;
  end
endmodule

// File: tb/tb_dual_port_memory.sv
// Bench for dual_port_memory: three configurations share one stimulus.
// Ports indexed 2*k (fetch) and 2*k+1 (data) for configuration k.
module tb_dual_port_memory;
  typedef struct {
    int          due;
    bit          f;
    logic [31:0] d;
    bit          known;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic        ire = 1'b0;
  logic [31:0] ia  = '0;
  logic        dre = 1'b0;
  logic        dwe = 1'b0;
  logic [3:0]  be  = '0;
  logic [31:0] da  = '0;
  logic [31:0] wd  = '0;

  logic        v  [6];
  logic        f  [6];
  logic [31:0] dd [6];

  int rl [3] = '{1, 1, 2};
  int wm [3] = '{0, 1, 0};

  initial forever #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dual_port_memory_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();
    assign bus.i_IReadEnable  = ire;
    assign bus.i_IAddress     = ia;
    assign bus.i_DReadEnable  = dre;
    assign bus.i_DWriteEnable = dwe;
    assign bus.i_DByteEnable  = be;
    assign bus.i_DAddress     = da;
    assign bus.i_DDataIn      = wd;
    assign v[2*g]    = bus.o_IValid;
    assign f[2*g]    = bus.o_IFault;
    assign dd[2*g]   = bus.o_IData;
    assign v[2*g+1]  = bus.o_DValid;
    assign f[2*g+1]  = bus.o_DFault;
    assign dd[2*g+1] = bus.o_DDataOut;
    dual_port_memory #(
      .DATA_WIDTH(32),
      .ADDR_WIDTH(32),
      .DEPTH_WORDS(16384),
      .READ_LATENCY(g == 2 ? 2 : 1),
      .WRITE_MODE(g == 1 ? 1 : 0)
    ) u_dut (
      .i_Clock(clk),
      .i_Reset(rst),
      .bus(bus.slave)
    );
  end

  logic [31:0] mem [int];
  exp_t        qq  [6][$];
  logic [31:0] hv  [6];
  bit          hk  [6];
  int          cyc  = 0;
  int          nchk = 0;
  int          nerr = 0;

  function automatic bit bad(input logic [31:0] a);
    return (a % 4 != 0) || (a >= 32'h0001_0000);
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a / 4) % 16384);
  endfunction

  task automatic ck(input string nm, input int p,
                    input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s port%0d cyc %0d: got %h want %h",
               nm, p, cyc, act, exp);
    end
  endtask

  // Reference model: acts on every accepted edge.
  initial begin : model
    exp_t        e;
    logic [31:0] old;
    logic [31:0] mrg;
    bit          ok;
    bit          mk;
    bit          fb;
    int          wi;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst !== 1'b0) continue;
      if (ire) begin
        fb = bad(ia);
        wi = widx(ia);
        e.f = fb;
        e.known = fb || mem.exists(wi);
        e.d = fb ? 32'h0 : (mem.exists(wi) ? mem[wi] : 32'h0);
        for (int k = 0; k < 3; k++) begin
          e.due = cyc + rl[k] - 1;
          qq[2*k].push_back(e);
        end
      end
      if (dre || dwe) begin
        fb  = bad(da);
        wi  = widx(da);
        ok  = mem.exists(wi);
        old = ok ? mem[wi] : 32'h0;
        mrg = old;
        for (int b = 0; b < 4; b++)
          if (be[b]) mrg[8*b +: 8] = wd[8*b +: 8];
        mk = ok || (be == 4'hF);
        for (int k = 0; k < 3; k++) begin
          e.due = cyc + rl[k] - 1;
          e.f   = fb;
          if (fb) begin
            e.d = 32'h0;
            e.known = 1'b1;
          end else if (dwe && wm[k] == 0) begin
            e.d = mrg;
            e.known = mk;
          end else begin
            e.d = old;
            e.known = ok;
          end
          qq[2*k+1].push_back(e);
        end
        if (dwe && !fb) begin
          if (mk) mem[wi] = mrg;
          else if (be != 4'h0) mem.delete(wi);
        end
      end
    end
  end

  // Compare every output of every configuration each cycle.
  initial begin : compare
    exp_t e;
    bit   ev;
    forever begin
      @(negedge clk);
      for (int p = 0; p < 6; p++) begin
        if (rst) begin
          qq[p].delete();
          hv[p] = 32'h0;
          hk[p] = 1'b1;
          ck("rst_valid", p, 32'(v[p]), 32'h0);
          ck("rst_fault", p, 32'(f[p]), 32'h0);
          ck("rst_data", p, dd[p], 32'h0);
        end else begin
          while (qq[p].size() > 0 && qq[p][0].due < cyc) begin
            nchk++;
            nerr++;
            $display("FAIL lost_response port%0d cyc %0d: got none want due %0d",
                     p, cyc, qq[p][0].due);
            void'(qq[p].pop_front());
          end
          ev = qq[p].size() > 0 && qq[p][0].due == cyc;
          ck("valid", p, 32'(v[p]), 32'(ev));
          if (ev) begin
            e = qq[p].pop_front();
            ck("fault", p, 32'(f[p]), 32'(e.f));
            if (e.known) ck("data", p, dd[p], e.d);
            hv[p] = e.d;
            hk[p] = e.known;
          end else begin
            ck("idle_fault", p, 32'(f[p]), 32'h0);
            if (hk[p]) ck("hold_data", p, dd[p], hv[p]);
          end
        end
      end
    end
  end

  task automatic drive(input bit i_e, input logic [31:0] i_a,
                       input bit r, input bit w, input logic [3:0] b,
                       input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    ire = i_e;
    ia  = i_a;
    dre = r;
    dwe = w;
    be  = b;
    da  = a;
    wd  = d;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  function automatic logic [31:0] raddr();
    int r;
    r = int'($urandom_range(0, 19));
    if (r == 0)
      return 32'h100 + 4 * $urandom_range(0, 7) + $urandom_range(1, 3);
    if (r == 1)
      return 32'h100 | (32'h1 << $urandom_range(16, 31));
    return 32'h100 + 4 * $urandom_range(0, 7);
  endfunction

  initial begin : stim
    repeat (2) @(negedge clk);
    @(posedge clk);
    #3 rst = 1'b0;

    drive(0, 0, 0, 1, 4'hF, 32'h100, 32'hDEADBEEF);
    drive(1, 32'h100, 0, 0, 4'h0, 0, 0);
    idle();
    ck("t1_ivalid", 0, 32'(v[0]), 32'h1);
    ck("t1_idata", 0, dd[0], 32'hDEADBEEF);
    ck("t1_ifault", 0, 32'(f[0]), 32'h0);

    drive(0, 0, 0, 1, 4'hF, 32'h200, 32'h11223344);
    drive(0, 0, 0, 1, 4'b0101, 32'h200, 32'hAABBCCDD);
    drive(0, 0, 1, 0, 4'h0, 32'h200, 0);
    idle();
    ck("t2_dvalid", 1, 32'(v[1]), 32'h1);
    ck("t2_ddata", 1, dd[1], 32'h11BB33DD);

    drive(0, 0, 0, 1, 4'hF, 32'h104, 32'h0);
    drive(1, 32'h104, 1, 1, 4'hF, 32'h104, 32'h5A5A5A5A);
    idle();
    ck("t3_wfirst", 1, dd[1], 32'h5A5A5A5A);
    ck("t3_rfirst", 3, dd[3], 32'h0);
    ck("t3_icoll0", 0, dd[0], 32'h0);
    ck("t3_icoll1", 2, dd[2], 32'h0);

    drive(0, 0, 0, 1, 4'hF, 32'h102, 32'h12345678);
    idle();
    ck("t4_dvalid", 1, 32'(v[1]), 32'h1);
    ck("t4_dfault", 1, 32'(f[1]), 32'h1);
    ck("t4_ddata", 1, dd[1], 32'h0);
    drive(1, 32'h0001_0000, 0, 0, 4'h0, 0, 0);
    idle();
    ck("t4_ifault", 0, 32'(f[0]), 32'h1);
    ck("t4_idata", 0, dd[0], 32'h0);
    drive(0, 0, 1, 0, 4'h0, 32'h100, 0);
    idle();
    ck("t4_unchanged", 1, dd[1], 32'hDEADBEEF);

    drive(0, 0, 0, 1, 4'hF, 32'h0, 32'h11111111);
    drive(0, 0, 0, 1, 4'hF, 32'h4, 32'h22222222);
    drive(0, 0, 0, 1, 4'hF, 32'h8, 32'h33333333);
    drive(1, 32'h0, 0, 0, 4'h0, 0, 0);
    drive(1, 32'h4, 0, 0, 4'h0, 0, 0);
    ck("t5_early", 4, 32'(v[4]), 32'h0);
    drive(1, 32'h8, 0, 0, 4'h0, 0, 0);
    ck("t5_v0", 4, 32'(v[4]), 32'h1);
    ck("t5_d0", 4, dd[4], 32'h11111111);
    idle();
    ck("t5_v1", 4, 32'(v[4]), 32'h1);
    ck("t5_d1", 4, dd[4], 32'h22222222);
    idle();
    ck("t5_v2", 4, 32'(v[4]), 32'h1);
    ck("t5_d2", 4, dd[4], 32'h33333333);
    idle();
    ck("t5_after", 4, 32'(v[4]), 32'h0);

    drive(1, 32'h4, 0, 0, 4'h0, 0, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    for (int p = 0; p < 6; p++) begin
      ck("t6_async_v", p, 32'(v[p]), 32'h0);
      ck("t6_async_d", p, dd[p], 32'h0);
    end
    @(posedge clk);
    #3 rst = 1'b0;
    idle();
    ck("t6_dropped", 4, 32'(v[4]), 32'h0);
    idle();
    ck("t6_dropped2", 4, 32'(v[4]), 32'h0);
    drive(1, 32'h100, 0, 0, 4'h0, 0, 0);
    idle();
    idle();
    ck("t6_kept_v", 4, 32'(v[4]), 32'h1);
    ck("t6_kept_d", 4, dd[4], 32'hDEADBEEF);

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 399) == 0) begin
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #3 rst = 1'b0;
      end
      drive(1'($urandom_range(0, 1)), raddr(),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            4'($urandom), raddr(), $urandom);
    end
    repeat (4) idle();
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
